// File: rtl/irq_seq_pkg.sv
// Shared state encodings and width helper for the interrupt entry sequencer.
package irq_seq_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ARB   = 3'd1;
   localparam logic [2:0] ST_SAVE  = 3'd2;
   localparam logic [2:0] ST_VECT  = 3'd3;
   localparam logic [2:0] ST_INSVC = 3'd4;

   // Width of a line index; never below one bit so single-bit ids stay legal.
   function automatic int idw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/irq_prio_arbiter.sv
// Picks one pending request line. Fixed lowest-index priority by default;
// rotating priority when IRQ_ROUND_ROBIN_EN is defined.
module irq_prio_arbiter
   import irq_seq_pkg::*;
#(
   parameter int NUM_IRQ = 8,
   parameter int IDW     = idw_of(NUM_IRQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] pending,
   input  logic               advance,
   input  logic [IDW-1:0]     served_id,
   output logic [IDW-1:0]     win_id,
   output logic               win_valid
);

`ifdef IRQ_ROUND_ROBIN_EN
   logic [IDW-1:0] ptr;

   // Scan starts at ptr and wraps; the first pending line found wins.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      win_id    = '0;
      win_valid = 1'b0;
      for (int k = 0; k < NUM_IRQ; k++) begin
         int idx;
         idx = (int'(ptr) + k) % NUM_IRQ;
         if (!win_valid && pending[idx]) begin
            win_valid = 1'b1;
            win_id    = idx[IDW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst)
         ptr <= '0;
      else if (advance)
         ptr <= (int'(served_id) == NUM_IRQ - 1) ? '0 : served_id + 1'b1;
   end
`else
   logic unused_rr;
   assign unused_rr = ^{clk, rst, advance, served_id};

   always_comb begin
      win_id    = '0;
      win_valid = |pending;
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
         if (pending[k])
            win_id = IDW'(k);
      end
   end
`endif

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt entry sequencer: edge-detects requests, waits for an instruction
// boundary, drives the regfile trap save and vectors the PC. Priority scheme
// selected by IRQ_ROUND_ROBIN_EN (undefined = fixed lowest-index priority).
module irq_sequencer
   import irq_seq_pkg::*;
#(
   parameter int          NUM_IRQ    = 8,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
   parameter int          VEC_STRIDE = 4,
   parameter int          IDW        = idw_of(NUM_IRQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_req,
   input  logic               int_en,
   input  logic               instr_done,
   input  logic               iret,
   output logic               stall,
   output logic               ir_tsf,
   output logic               ks,
   output logic               pc_load,
   output logic [31:0]        pc_vec,
   output logic [NUM_IRQ-1:0] irq_ack,
   output logic [IDW-1:0]     active_id,
   output logic               busy
);

   logic [2:0]         state, state_nxt;
   logic [NUM_IRQ-1:0] pending, prev_req, rise, ack_mask, clr_mask;
   logic [IDW-1:0]     win_id;
   logic               win_valid, take;

   irq_prio_arbiter #(.NUM_IRQ(NUM_IRQ), .IDW(IDW)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .pending   (pending),
      .advance   (state == ST_VECT),
      .served_id (active_id),
      .win_id    (win_id),
      .win_valid (win_valid)
   );

   assign rise     = irq_req & ~prev_req;
   assign ack_mask = {{(NUM_IRQ-1){1'b0}}, 1'b1} << active_id;
   assign clr_mask = (state == ST_VECT) ? ack_mask : '0;
   assign take     = (state == ST_IDLE) && win_valid && int_en;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (take) state_nxt = ST_ARB;
         ST_ARB:   if (!int_en) state_nxt = ST_IDLE;
                   else if (instr_done) state_nxt = ST_SAVE;
         ST_SAVE:  state_nxt = ST_VECT;
         ST_VECT:  state_nxt = ST_INSVC;
         ST_INSVC: if (iret) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // prev_req resets high so a line already asserted at reset release is not an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         pending   <= '0;
         prev_req  <= '1;
         active_id <= '0;
         pc_vec    <= VEC_BASE;
      end else begin
         state    <= state_nxt;
         prev_req <= irq_req;
         pending  <= (pending & ~clr_mask) | rise;
         if (take) begin
            active_id <= win_id;
            pc_vec    <= VEC_BASE + 32'(win_id) * 32'(VEC_STRIDE);
         end
      end
   end

   assign stall   = (state == ST_ARB) || (state == ST_SAVE) || (state == ST_VECT);
   assign ir_tsf  = (state == ST_SAVE);
   assign ks      = (state == ST_SAVE);
   assign pc_load = (state == ST_VECT);
   assign irq_ack = (state == ST_VECT) ? ack_mask : '0;
   assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed self-checking bench for irq_sequencer; expectations follow the
// priority mode selected by IRQ_ROUND_ROBIN_EN.
module tb_irq_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  irq_req;
   logic        int_en, instr_done, iret;
   logic        stall, ir_tsf, ks, pc_load, busy;
   logic [31:0] pc_vec;
   logic [7:0]  irq_ack;
   logic [2:0]  active_id;

   int n_vec = 0;
   int n_err = 0;

   irq_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .irq_req    (irq_req),
      .int_en     (int_en),
      .instr_done (instr_done),
      .iret       (iret),
      .stall      (stall),
      .ir_tsf     (ir_tsf),
      .ks         (ks),
      .pc_load    (pc_load),
      .pc_vec     (pc_vec),
      .irq_ack    (irq_ack),
      .active_id  (active_id),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_stall"},   stall,     0);
      check({tag, "_tsf"},     {ir_tsf, ks, pc_load}, 0);
      check({tag, "_ack"},     irq_ack,   0);
      check({tag, "_busy"},    busy,      0);
      check({tag, "_pcvec"},   pc_vec,    32'h100);
      check({tag, "_id"},      active_id, 0);
   endtask

   // Waits for ARB, retires an instruction, checks SAVE/VECT/INSVC; optionally returns via iret.
   task automatic serve(input string tag, input int id, input bit do_iret);
      bit found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (stall && !ir_tsf && !pc_load) found = 1;
         else tick();
      end
      check({tag, "_arb_seen"}, found, 1);
      if (!found) return;
      instr_done = 1'b1; tick(); instr_done = 1'b0;
      check({tag, "_save"}, {stall, ir_tsf, ks, pc_load}, 4'b1110);
      tick();
      check({tag, "_vect"},  {stall, ir_tsf, pc_load}, 3'b101);
      check({tag, "_pcvec"}, pc_vec, 32'h100 + 32'(id) * 4);
      check({tag, "_ack"},   irq_ack, 32'(1) << id);
      check({tag, "_id"},    active_id, id);
      tick();
      check({tag, "_insvc"}, {stall, busy, pc_load}, 3'b010);
      if (do_iret) begin
         iret = 1'b1; tick(); iret = 1'b0;
         check({tag, "_idle"}, busy, 0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
   endtask

   initial begin
      irq_req = '0; int_en = 1'b1; instr_done = 1'b0; iret = 1'b0;
      do_reset();
      check_reset_outputs("rst0");
      tick();

      // 1: line 5 edge, boundary three cycles after ARB entry.
      iret = 1'b1; tick(); iret = 1'b0;
      check("t1_iret_idle", busy, 0);
      irq_req[5] = 1'b1; tick();
      check("t1_pend_cycle", {stall, busy}, 2'b00);
      tick();
      check("t1_arb", {stall, busy, ir_tsf}, 3'b110);
      tick(); tick();
      check("t1_arb_hold", {stall, ir_tsf, pc_load}, 3'b100);
      instr_done = 1'b1; tick(); instr_done = 1'b0;
      check("t1_save", {stall, ir_tsf, ks, pc_load}, 4'b1110);
      tick();
      check("t1_vect", {pc_load, ir_tsf, ks}, 3'b100);
      check("t1_pcvec", pc_vec, 32'h114);
      check("t1_ack", irq_ack, 8'h20);
      tick();
      check("t1_insvc", {stall, busy, pc_load, irq_ack}, {3'b010, 8'h00});
      instr_done = 1'b1; tick(); instr_done = 1'b0;
      check("t1_done_ignored", {stall, busy, ir_tsf}, 3'b010);
      iret = 1'b1; tick(); iret = 1'b0;
      check("t1_idle", busy, 0);
      irq_req = '0; tick(); tick();
      check("t1_no_refire", busy, 0);

      // 2: lines 2 and 6 together; 2 first, 6 after iret.
      do_reset(); tick();
      irq_req = 8'h44;
      serve("t2_first", 2, 1);
      serve("t2_second", 6, 1);
      irq_req = '0; tick(); tick();
      check("t2_drained", busy, 0);

      // 3: while line 2 is in service, re-raise 2 and raise 3 with 6 still pending.
      irq_req = 8'h44;
      serve("t3_a", 2, 0);
      irq_req[2] = 1'b0; tick();
      irq_req[2] = 1'b1; irq_req[3] = 1'b1; tick(); tick();
      iret = 1'b1; tick(); iret = 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
      serve("t3_b", 3, 1);
      serve("t3_c", 6, 1);
      serve("t3_d", 2, 1);
`else
      serve("t3_b", 2, 1);
      serve("t3_c", 3, 1);
      serve("t3_d", 6, 1);
`endif
      irq_req = '0; tick(); tick();
      check("t3_drained", busy, 0);

      // 4: int_en drops in ARB, pending survives and entry completes later.
      irq_req[1] = 1'b1; tick(); tick();
      check("t4_arb", stall, 1);
      int_en = 1'b0; tick();
      check("t4_abort", {stall, busy, ir_tsf}, 3'b000);
      tick(); tick();
      check("t4_wait", {stall, busy}, 2'b00);
      int_en = 1'b1;
      serve("t4_resume", 1, 1);
      irq_req = '0; tick();

      // 5: line 7 held through reset never fires; edge on 0 during INSVC waits for iret.
      irq_req[7] = 1'b1;
      do_reset();
      check_reset_outputs("t5_rst");
      tick(); tick(); tick();
      check("t5_held_quiet", {busy, stall}, 2'b00);
      irq_req[4] = 1'b1;
      serve("t5_line4", 4, 0);
      irq_req[0] = 1'b1; tick(); tick(); tick();
      check("t5_no_nest", {busy, stall, pc_load}, 3'b100);
      check("t5_id_kept", active_id, 4);
      iret = 1'b1; tick(); iret = 1'b0;
      serve("t5_line0", 0, 1);
      tick(); tick(); tick();
      check("t5_quiet", busy, 0);
      irq_req = '0; tick();

      // 6: reset while in SAVE.
      irq_req[3] = 1'b1; tick(); tick();
      check("t6_arb", stall, 1);
      instr_done = 1'b1; tick(); instr_done = 1'b0;
      check("t6_save", ir_tsf, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      check_reset_outputs("t6_rst");
      tick(); tick(); tick(); tick();
      check("t6_pending_clr", {busy, stall}, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
